// File: rtl/wired_rob_alloc.sv
// ROB id allocator: hands out up to two ROB ids per cycle from a circular
// tail pointer and retires up to two entries in order from the head.
// Pointers carry the wrap (tier) bit as their MSB so tier toggling on wrap
// falls out of plain RW+1-bit addition.
module wired_rob_alloc #(
    parameter int unsigned DEPTH = 32,
    localparam int unsigned RW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alloc_valid_i,
    input  logic [1:0]      alloc_mask_i,
    input  logic            p_ready_i,
    output logic            alloc_ready_o,
    output logic [2*RW-1:0] alloc_rid_o,
    output logic [1:0]      alloc_tier_o,
    input  logic [1:0]      retire_i,
    output logic [2*RW-1:0] retire_rid_o,
    output logic [1:0]      retire_tier_o,
    input  logic            flush_i,
    output logic [RW:0]     count_o,
    output logic            empty_o,
    output logic            full_o
);

    localparam logic [RW:0] DEPTH_W = {1'b1, {RW{1'b0}}};

    logic [RW:0] tail_q, tail_d;
    logic [RW:0] head_q, head_d;
    logic [RW:0] count_q, count_d;

    logic [1:0]  n_alloc, n_ret;
    logic [RW:0] n_alloc_w, n_ret_w;
    logic [RW:0] free_w, avail_w, ret_eff_w;
    logic [RW:0] tail_p1, head_p1, slot1_ptr;
    logic        fire;
    logic        ill_retire_order, ill_retire_under;

    // Request/retire sizes, readiness and fire decision.
    always_comb begin
        n_alloc   = {1'b0, alloc_mask_i[0]} + {1'b0, alloc_mask_i[1]};
        n_ret     = {1'b0, retire_i[0]} + {1'b0, retire_i[1]};
        n_alloc_w = {{(RW-1){1'b0}}, n_alloc};
        n_ret_w   = {{(RW-1){1'b0}}, n_ret};
        // Free space deliberately ignores same-cycle retires so ready never depends on retire_i.
        free_w        = DEPTH_W - count_q;
        alloc_ready_o = p_ready_i & ~flush_i & (free_w >= n_alloc_w);
        fire          = alloc_valid_i & alloc_ready_o & (|alloc_mask_i);
    end

    // Compacted id assignment and retire-side id presentation.
    always_comb begin
        tail_p1   = tail_q + 1'b1;
        head_p1   = head_q + 1'b1;
        // A lone request in slot 1 takes the tail id; otherwise slot 1 sees tail+1.
        slot1_ptr = (alloc_mask_i == 2'b10) ? tail_q : tail_p1;
        alloc_rid_o   = {slot1_ptr[RW-1:0], tail_q[RW-1:0]};
        alloc_tier_o  = {slot1_ptr[RW], tail_q[RW]};
        retire_rid_o  = {head_p1[RW-1:0], head_q[RW-1:0]};
        retire_tier_o = {head_p1[RW], head_q[RW]};
    end

    // Next-state computation; flush wins, over-retire saturates at empty.
    always_comb begin
        avail_w   = count_q + (fire ? n_alloc_w : '0);
        ret_eff_w = (n_ret_w > avail_w) ? avail_w : n_ret_w;
        ill_retire_order = ~flush_i & (retire_i == 2'b10);
        ill_retire_under = ~flush_i & (n_ret_w > avail_w);
        if (flush_i) begin
            tail_d  = '0;
            head_d  = '0;
            count_d = '0;
        end else begin
            tail_d  = tail_q + (fire ? n_alloc_w : '0);
            head_d  = head_q + ret_eff_w;
            count_d = avail_w - ret_eff_w;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tail_q  <= '0;
            head_q  <= '0;
            count_q <= '0;
        end else begin
            tail_q  <= tail_d;
            head_q  <= head_d;
            count_q <= count_d;
        end
    end

`ifndef SYNTHESIS
    logic ill_order_seen_q, ill_under_seen_q;

    // Sticky flags recording any illegal retire request seen in simulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ill_order_seen_q <= 1'b0;
            ill_under_seen_q <= 1'b0;
        end else begin
            ill_order_seen_q <= ill_order_seen_q | ill_retire_order;
            ill_under_seen_q <= ill_under_seen_q | ill_retire_under;
        end
    end
`endif

    // Status outputs come straight from registered occupancy.
    always_comb begin
        count_o = count_q;
        empty_o = (count_q == '0);
        full_o  = (count_q == DEPTH_W);
    end

endmodule

// File: tb/tb_wired_rob_alloc.sv
// Self-checking bench for wired_rob_alloc: reset checks, a directed vector
// table, hand-written corner sequences and a randomized run against an
// arithmetic model of head/tail positions.
module tb_wired_rob_alloc;

    localparam int D  = 32;
    localparam int RW = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            av = 1'b0, pr = 1'b0, fl = 1'b0;
    logic [1:0]      am = 2'b00, rt = 2'b00;
    logic            alloc_ready;
    logic [2*RW-1:0] alloc_rid, retire_rid;
    logic [1:0]      alloc_tier, retire_tier;
    logic [RW:0]     count;
    logic            empty, full;

    int checks = 0;
    int errors = 0;

    wired_rob_alloc #(.DEPTH(D)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alloc_valid_i(av),
        .alloc_mask_i (am),
        .p_ready_i    (pr),
        .alloc_ready_o(alloc_ready),
        .alloc_rid_o  (alloc_rid),
        .alloc_tier_o (alloc_tier),
        .retire_i     (rt),
        .retire_rid_o (retire_rid),
        .retire_tier_o(retire_tier),
        .flush_i      (fl),
        .count_o      (count),
        .empty_o      (empty),
        .full_o       (full)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drv(input bit v, input bit [1:0] m, input bit p,
                       input bit [1:0] r, input bit f);
        av = v; am = m; pr = p; rt = r; fl = f;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        av = 0; am = 0; pr = 0; rt = 0; fl = 0;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    function automatic int aid(input int s);
        return (s == 0) ? int'(alloc_rid[RW-1:0]) : int'(alloc_rid[2*RW-1:RW]);
    endfunction

    function automatic int rid(input int s);
        return (s == 0) ? int'(retire_rid[RW-1:0]) : int'(retire_rid[2*RW-1:RW]);
    endfunction

    typedef struct {
        bit       v;
        bit [1:0] m;
        bit       p;
        bit [1:0] r;
        bit       f;
        bit       e_rdy;
        int       e_id0;
        int       e_id1;
        int       e_ret0;
        int       e_cnt;
    } vec_t;

    vec_t vt[8];

    // Model state: absolute positions modulo 2*D, tier = pos / D.
    int m_tail, m_head, m_cnt;

    initial begin
        // Directed table, applied in order straight after reset.
        vt[0] = '{1, 2'b11, 1, 2'b00, 0, 1, 0, 1, 0, 0};
        vt[1] = '{1, 2'b10, 1, 2'b00, 0, 1, 0, 2, 0, 2};
        vt[2] = '{1, 2'b01, 0, 2'b01, 0, 0, 3, 0, 0, 3};
        vt[3] = '{0, 2'b11, 1, 2'b11, 0, 1, 3, 4, 1, 2};
        vt[4] = '{1, 2'b11, 1, 2'b00, 1, 0, 3, 4, 3, 0};
        vt[5] = '{1, 2'b01, 1, 2'b00, 0, 1, 0, 0, 0, 0};
        vt[6] = '{1, 2'b00, 1, 2'b01, 0, 1, 0, 0, 0, 1};
        vt[7] = '{0, 2'b00, 1, 2'b00, 0, 1, 0, 0, 1, 0};

        // Values held while reset is asserted.
        av = 0; am = 2'b00; pr = 1; rt = 0; fl = 0;
        #3;
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_alloc_rid0", aid(0), 0);
        chk("rst_alloc_rid1", aid(1), 1);
        chk("rst_alloc_tier", int'(alloc_tier), 0);
        chk("rst_retire_rid0", rid(0), 0);
        chk("rst_retire_rid1", rid(1), 1);
        chk("rst_retire_tier", int'(retire_tier), 0);
        chk("rst_ready", int'(alloc_ready), 1);
        #19;
        rst_n = 1'b1;
        tick();

        foreach (vt[i]) begin
            drv(vt[i].v, vt[i].m, vt[i].p, vt[i].r, vt[i].f);
            chk($sformatf("vec%0d_count", i), int'(count), vt[i].e_cnt);
            chk($sformatf("vec%0d_empty", i), int'(empty), int'(vt[i].e_cnt == 0));
            chk($sformatf("vec%0d_ready", i), int'(alloc_ready), int'(vt[i].e_rdy));
            if (vt[i].m[0]) begin
                chk($sformatf("vec%0d_id0", i), aid(0), vt[i].e_id0);
                chk($sformatf("vec%0d_tier0", i), int'(alloc_tier[0]), 0);
            end
            if (vt[i].m[1]) begin
                chk($sformatf("vec%0d_id1", i), aid(1), vt[i].e_id1);
                chk($sformatf("vec%0d_tier1", i), int'(alloc_tier[1]), 0);
            end
            chk($sformatf("vec%0d_ret0", i), rid(0), vt[i].e_ret0);
            chk($sformatf("vec%0d_ret1", i), rid(1), vt[i].e_ret0 + 1);
            tick();
        end

        // Fill with pairs: ids (0,1)..(30,31), then full and not ready.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drv(1, 2'b11, 1, 2'b00, 0);
            chk("fill_ready", int'(alloc_ready), 1);
            chk("fill_id0", aid(0), 2*i);
            chk("fill_id1", aid(1), 2*i + 1);
            chk("fill_tier", int'(alloc_tier), 0);
            tick();
        end
        drv(1, 2'b11, 1, 2'b00, 0);
        chk("fill_full", int'(full), 1);
        chk("fill_count", int'(count), 32);
        chk("fill_not_ready", int'(alloc_ready), 0);

        // Full + retire two: ready stays low this cycle, wrapped id next cycle.
        drv(1, 2'b01, 1, 2'b11, 0);
        chk("fullret_ready", int'(alloc_ready), 0);
        tick();
        drv(1, 2'b01, 1, 2'b00, 0);
        chk("fullret_count", int'(count), 30);
        chk("fullret_ready2", int'(alloc_ready), 1);
        chk("fullret_id0", aid(0), 0);
        chk("fullret_tier0", int'(alloc_tier[0]), 1);
        chk("fullret_head", rid(0), 2);
        tick();

        // One free entry: a pair is refused, a single is taken.
        drv(1, 2'b11, 1, 2'b00, 0);
        chk("c31_count", int'(count), 31);
        chk("c31_pair_ready", int'(alloc_ready), 0);
        tick();
        drv(1, 2'b01, 1, 2'b00, 0);
        chk("c31_hold_count", int'(count), 31);
        chk("c31_single_ready", int'(alloc_ready), 1);
        chk("c31_single_id", aid(0), 1);
        chk("c31_single_tier", int'(alloc_tier[0]), 1);
        tick();
        drv(0, 2'b00, 1, 2'b00, 0);
        chk("c31_full", int'(full), 1);
        chk("c31_count32", int'(count), 32);

        // Pair straddling the wrap at tail = 31.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            drv(1, 2'b11, 1, 2'b00, 0);
            tick();
        end
        drv(1, 2'b01, 1, 2'b00, 0);
        tick();
        drv(0, 2'b00, 1, 2'b11, 0);
        tick();
        drv(1, 2'b11, 1, 2'b00, 0);
        chk("wrap_count", int'(count), 29);
        chk("wrap_ready", int'(alloc_ready), 1);
        chk("wrap_id0", aid(0), 31);
        chk("wrap_tier0", int'(alloc_tier[0]), 0);
        chk("wrap_id1", aid(1), 0);
        chk("wrap_tier1", int'(alloc_tier[1]), 1);
        tick();
        drv(1, 2'b01, 1, 2'b00, 0);
        chk("wrap_count2", int'(count), 31);
        chk("wrap_tail", aid(0), 1);
        chk("wrap_tail_tier", int'(alloc_tier[0]), 1);

        // Lone slot-1 request at tail = 5.
        do_reset();
        drv(1, 2'b11, 1, 2'b00, 0); tick();
        drv(1, 2'b11, 1, 2'b00, 0); tick();
        drv(1, 2'b01, 1, 2'b00, 0); tick();
        drv(1, 2'b10, 1, 2'b00, 0);
        chk("m10_ready", int'(alloc_ready), 1);
        chk("m10_id1", aid(1), 5);
        chk("m10_tier1", int'(alloc_tier[1]), 0);
        tick();
        drv(1, 2'b01, 1, 2'b00, 0);
        chk("m10_count", int'(count), 6);
        chk("m10_tail", aid(0), 6);

        // Flush with alloc and retire in the same cycle.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drv(1, 2'b11, 1, 2'b00, 0);
            tick();
        end
        drv(1, 2'b11, 1, 2'b11, 1);
        chk("flush_pre_count", int'(count), 12);
        chk("flush_ready", int'(alloc_ready), 0);
        tick();
        drv(1, 2'b11, 1, 2'b00, 0);
        chk("flush_count", int'(count), 0);
        chk("flush_empty", int'(empty), 1);
        chk("flush_head", rid(0), 0);
        chk("flush_head_tier", int'(retire_tier), 0);
        chk("flush_id0", aid(0), 0);
        chk("flush_id1", aid(1), 1);
        chk("flush_tier", int'(alloc_tier), 0);
        tick();

        // Reset pulse mid-stream at count = 12.
        for (int i = 0; i < 5; i++) begin
            drv(1, 2'b11, 1, 2'b00, 0);
            tick();
        end
        chk("rstpulse_pre_count", int'(count), 12);
        rst_n = 1'b0;
        #1;
        chk("rstpulse_count", int'(count), 0);
        chk("rstpulse_empty", int'(empty), 1);
        chk("rstpulse_head", rid(0), 0);
        chk("rstpulse_id0", aid(0), 0);
        chk("rstpulse_id1", aid(1), 1);
        chk("rstpulse_tier", int'(alloc_tier), 0);
        chk("rstpulse_ready", int'(alloc_ready), 1);
        #1;
        rst_n = 1'b1;
        tick();
        drv(0, 2'b00, 1, 2'b00, 0);
        chk("rstpulse_post_count", int'(count), 2);

        // Randomized run against the position model.
        do_reset();
        m_tail = 0; m_head = 0; m_cnt = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            bit v, p, f;
            bit [1:0] m, r;
            int sel, na, nr, k, pos, add, avail, re;
            bit e_rdy;
            v = ($urandom_range(0, 9) != 0);
            m = 2'($urandom);
            p = ($urandom_range(0, 7) != 0);
            sel = $urandom_range(0, 15);
            if ((cyc / 250) % 2 == 0) sel = sel / 2;  // fill-biased phases
            r = (sel < 6) ? 2'b00 : (sel < 10) ? 2'b01 : (sel < 14) ? 2'b11 : 2'b10;
            f = ($urandom_range(0, 99) == 0);
            drv(v, m, p, r, f);

            na = int'(m[0]) + int'(m[1]);
            nr = int'(r[0]) + int'(r[1]);
            e_rdy = p && !f && ((D - m_cnt) >= na);
            chk("rnd_count", int'(count), m_cnt);
            chk("rnd_empty", int'(empty), int'(m_cnt == 0));
            chk("rnd_full", int'(full), int'(m_cnt == D));
            chk("rnd_ready", int'(alloc_ready), int'(e_rdy));
            k = 0;
            for (int s = 0; s < 2; s++) begin
                if (m[s]) begin
                    pos = (m_tail + k) % (2*D);
                    chk("rnd_alloc_id", aid(s), pos % D);
                    chk("rnd_alloc_tier", int'(alloc_tier[s]), pos / D);
                    k++;
                end
            end
            for (int s = 0; s < 2; s++) begin
                pos = (m_head + s) % (2*D);
                chk("rnd_retire_id", rid(s), pos % D);
                chk("rnd_retire_tier", int'(retire_tier[s]), pos / D);
            end
            tick();

            if (f) begin
                m_tail = 0; m_head = 0; m_cnt = 0;
            end else begin
                add   = (v && e_rdy) ? na : 0;
                avail = m_cnt + add;
                re    = (nr > avail) ? avail : nr;
                m_cnt  = avail - re;
                m_tail = (m_tail + add) % (2*D);
                m_head = (m_head + re) % (2*D);
            end
        end
        drv(0, 2'b00, 1, 2'b00, 0);
        chk("rnd_final_count", int'(count), m_cnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
